// File: rtl/speech_queue_controller_if.sv
`timescale 1ns/1ps
// speech_queue_controller_if
// CPU-side write handshake between the bus master and the speech queue controller.
//   VoiceControl_H : write strobe, held high by the master until VoiceDtack_L is seen low
//   data           : write word, valid while VoiceControl_H is high
//   VoiceDtack_L   : active-low data acknowledge returned by the controller
// Modports: master (CPU side) and slave (controller side).
interface speech_queue_controller_if #(
    parameter int DATA_W = 16
) ();
    logic              VoiceControl_H;
    logic [DATA_W-1:0] data;
    logic              VoiceDtack_L;

    modport master (output VoiceControl_H, output data, input VoiceDtack_L);
    modport slave  (input VoiceControl_H, input data, output VoiceDtack_L);
endinterface

// File: rtl/speech_queue_controller.sv
`timescale 1ns/1ps
// speech_queue_controller
// Queued phoneme playback controller between the CPU bus and the phoneme speech engine.
// A CPU write is unpacked into PHON_W-bit lanes (lane 0 first). Non-zero lanes are pushed into a
// DEPTH-entry FIFO and the write is then acknowledged. The playback FSM drains the FIFO one phoneme
// at a time over the engine's start/busy handshake, abandoning a phoneme whose start is not
// answered with busy within START_TIMEOUT cycles.
// Ports:
//   clk                   : system clock, rising edge
//   rst_L                 : asynchronous active-low reset
//   bus                   : write handshake (VoiceControl_H, data in; VoiceDtack_L out), slave modport
//   phoneme_speech_busy   : engine busy
//   phoneme_sel           : registered phoneme code to the engine
//   start_phoneme_output  : start request to the engine
//   phoneme_speech_finish : one-cycle pulse per phoneme completed or abandoned
//   queue_level           : current FIFO occupancy
//   speech_idle           : FIFO empty and playback idle
//   timeout_err           : sticky start-timeout flag, cleared by the next accepted write
// Optional feature (macro SPEECH_QUEUE_ABORT_EN): an all-ones write is an abort command that flushes
// the FIFO and cancels the phoneme in flight without a finish pulse. Without the macro an all-ones
// word is ordinary phoneme data.
module speech_queue_controller #(
    parameter int DATA_W        = 16,
    parameter int PHON_W        = 8,
    parameter int DEPTH         = 16,
    parameter int START_TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst_L,
    speech_queue_controller_if.slave   bus,
    input  logic                       phoneme_speech_busy,
    output logic [PHON_W-1:0]          phoneme_sel,
    output logic                       start_phoneme_output,
    output logic                       phoneme_speech_finish,
    output logic [$clog2(DEPTH+1)-1:0] queue_level,
    output logic                       speech_idle,
    output logic                       timeout_err
);
    localparam int LANES  = DATA_W / PHON_W;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int TW     = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

    localparam logic [CW-1:0]     FULL_LEVEL = CW'(DEPTH);
    localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(LANES - 1);
    localparam logic [TW-1:0]     TIMER_LAST = TW'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {B_IDLE, B_PUSH, B_ACK} bus_state_t;
`ifdef SPEECH_QUEUE_ABORT_EN
    typedef enum logic [2:0] {P_IDLE, P_START, P_PLAY, P_DONE, P_DRAIN} play_state_t;
`else
    typedef enum logic [1:0] {P_IDLE, P_START, P_PLAY, P_DONE} play_state_t;
`endif

    bus_state_t        bus_state, bus_next;
    play_state_t       play_state, play_next;

    logic [DATA_W-1:0] word_q;
    logic [LANE_W-1:0] lane_q;
    logic [PHON_W-1:0] lane_val;
    logic              accept;
    logic              push_en;
    logic              lane_stall;
    logic              dtack_n;
    logic              pop_en;
    logic              timeout_hit;

    logic [PHON_W-1:0] fifo_mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [TW-1:0]     timer;

`ifdef SPEECH_QUEUE_ABORT_EN
    logic              abort_q;
    logic              flush;
`endif

    assign lane_val         = word_q[int'(lane_q)*PHON_W +: PHON_W];
    assign bus.VoiceDtack_L = dtack_n;
    assign queue_level      = count;
    assign speech_idle      = (count == '0) && (play_state == P_IDLE);

    // State registers for both FSMs.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            bus_state  <= B_IDLE;
            play_state <= P_IDLE;
        end else begin
            bus_state  <= bus_next;
            play_state <= play_next;
        end
    end

    // Bus FSM next state: a lane that stalls on a full FIFO holds the walk in place.
    always_comb begin
        bus_next = bus_state;
        case (bus_state)
            B_IDLE:  if (bus.VoiceControl_H) bus_next = B_PUSH;
            B_PUSH:  if (!lane_stall && (lane_q == LAST_LANE)) bus_next = B_ACK;
            B_ACK:   if (!bus.VoiceControl_H) bus_next = B_IDLE;
            default: bus_next = B_IDLE;
        endcase
    end

    // Bus FSM outputs. The full check uses the count before any same-cycle pop.
    always_comb begin
        accept     = 1'b0;
        push_en    = 1'b0;
        lane_stall = 1'b0;
        dtack_n    = 1'b1;
`ifdef SPEECH_QUEUE_ABORT_EN
        flush      = 1'b0;
`endif
        case (bus_state)
            B_IDLE: accept = bus.VoiceControl_H;
            B_PUSH: begin
`ifdef SPEECH_QUEUE_ABORT_EN
                if (abort_q) begin
                    flush = (lane_q == '0);
                end else
`endif
                if (lane_val != '0) begin
                    if (count < FULL_LEVEL) push_en = 1'b1;
                    else                    lane_stall = 1'b1;
                end
            end
            B_ACK:  dtack_n = ~bus.VoiceControl_H;
            default: ;
        endcase
    end

    // Write word capture and lane walk.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            word_q  <= '0;
            lane_q  <= '0;
`ifdef SPEECH_QUEUE_ABORT_EN
            abort_q <= 1'b0;
`endif
        end else if (accept) begin
            word_q  <= bus.data;
            lane_q  <= '0;
`ifdef SPEECH_QUEUE_ABORT_EN
            abort_q <= &bus.data;
`endif
        end else if ((bus_state == B_PUSH) && !lane_stall && (lane_q != LAST_LANE)) begin
            lane_q  <= lane_q + LANE_W'(1);
        end
    end

    // FIFO storage has no reset; only the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push_en) fifo_mem[wr_ptr] <= lane_val;
    end

    // FIFO pointers and occupancy. A push and pop together leave the count unchanged.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
`ifdef SPEECH_QUEUE_ABORT_EN
            if (flush) begin
                rd_ptr <= wr_ptr;
                count  <= '0;
            end else begin
`endif
                if (push_en) wr_ptr <= wr_ptr + AW'(1);
                if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push_en) - CW'(pop_en);
`ifdef SPEECH_QUEUE_ABORT_EN
            end
`endif
        end
    end

    // Playback FSM next state: busy takes priority over the timeout in P_START.
    always_comb begin
        play_next = play_state;
        case (play_state)
            P_IDLE:  if (pop_en) play_next = P_START;
            P_START: begin
`ifdef SPEECH_QUEUE_ABORT_EN
                if (flush) play_next = P_DRAIN;
                else
`endif
                if (phoneme_speech_busy)        play_next = P_PLAY;
                else if (timer == TIMER_LAST)   play_next = P_DONE;
            end
            P_PLAY: begin
`ifdef SPEECH_QUEUE_ABORT_EN
                if (flush) play_next = P_DRAIN;
                else
`endif
                if (!phoneme_speech_busy)       play_next = P_DONE;
            end
            P_DONE:  play_next = P_IDLE;
`ifdef SPEECH_QUEUE_ABORT_EN
            P_DRAIN: if (!phoneme_speech_busy) play_next = P_IDLE;
`endif
            default: play_next = P_IDLE;
        endcase
    end

    // Playback FSM outputs and internal strobes. An abort blocks the pop in the flush cycle.
    always_comb begin
        start_phoneme_output  = (play_state == P_START);
        phoneme_speech_finish = (play_state == P_DONE);
        pop_en      = (play_state == P_IDLE) && (count != '0);
        timeout_hit = (play_state == P_START) && !phoneme_speech_busy && (timer == TIMER_LAST);
`ifdef SPEECH_QUEUE_ABORT_EN
        if (flush) begin
            pop_en      = 1'b0;
            timeout_hit = 1'b0;
        end
`endif
    end

    // Phoneme register, start timer and sticky timeout flag. A timeout in the same cycle as an
    // accepted write wins, so the error is never lost.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            phoneme_sel <= '0;
            timer       <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (pop_en) begin
                phoneme_sel <= fifo_mem[rd_ptr];
                timer       <= '0;
            end else if (play_state == P_START) begin
                timer       <= timer + TW'(1);
            end
            if (timeout_hit)  timeout_err <= 1'b1;
            else if (accept)  timeout_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_speech_queue_controller.sv
`timescale 1ns/1ps
// tb_speech_queue_controller
// Self-checking bench for speech_queue_controller at default parameters (macro undefined).
// A queue-based reference model predicts every output each cycle; directed scenarios add
// hand-computed expectations for ack latency, play order, full-queue stall, timeout and reset.
module tb_speech_queue_controller;
    localparam int DATA_W = 16;
    localparam int PHON_W = 8;
    localparam int DEPTH  = 16;
    localparam int LANES  = DATA_W / PHON_W;
    localparam int TMO    = 1024;

    logic       clk;
    logic       rst_L;
    logic       busy;
    logic [7:0] phoneme_sel;
    logic       start_phoneme_output;
    logic       phoneme_speech_finish;
    logic [4:0] queue_level;
    logic       speech_idle;
    logic       timeout_err;

    speech_queue_controller_if #(.DATA_W(DATA_W)) bus_if ();

    speech_queue_controller #(
        .DATA_W(DATA_W), .PHON_W(PHON_W), .DEPTH(DEPTH), .START_TIMEOUT(TMO)
    ) dut (
        .clk                  (clk),
        .rst_L                (rst_L),
        .bus                  (bus_if),
        .phoneme_speech_busy  (busy),
        .phoneme_sel          (phoneme_sel),
        .start_phoneme_output (start_phoneme_output),
        .phoneme_speech_finish(phoneme_speech_finish),
        .queue_level          (queue_level),
        .speech_idle          (speech_idle),
        .timeout_err          (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    bit check_en     = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a phoneme queue, the write in progress and the phoneme being played.
    localparam int M_IDLE = 0, M_WAIT_BUSY = 1, M_PLAYING = 2, M_FINISH = 3;
    logic [7:0]  m_q[$];
    bit          m_wr_active, m_wr_ack, m_terr;
    int          m_lane, m_phase, m_wait;
    logic [15:0] m_word;
    logic [7:0]  m_sel;

    always @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            m_q.delete();
            m_wr_active = 0; m_wr_ack = 0; m_terr = 0;
            m_lane = 0; m_phase = M_IDLE; m_wait = 0; m_word = '0; m_sel = '0;
        end else begin : model_step
            int pre;
            bit set_err, clr_err;
            logic [7:0] v;
            pre = m_q.size();
            set_err = 0; clr_err = 0;
            case (m_phase)
                M_IDLE: if (pre > 0) begin
                    m_sel = m_q.pop_front(); m_phase = M_WAIT_BUSY; m_wait = 0;
                end
                M_WAIT_BUSY: begin
                    if (busy) m_phase = M_PLAYING;
                    else if (m_wait == TMO - 1) begin m_phase = M_FINISH; set_err = 1; end
                    else m_wait++;
                end
                M_PLAYING: if (!busy) m_phase = M_FINISH;
                default:   m_phase = M_IDLE;
            endcase
            if (!m_wr_active) begin
                if (bus_if.VoiceControl_H) begin
                    m_wr_active = 1; m_wr_ack = 0; m_lane = 0;
                    m_word = bus_if.data; clr_err = 1;
                end
            end else if (!m_wr_ack) begin
                v = m_word[m_lane*8 +: 8];
                if (v == 0 || pre < DEPTH) begin
                    if (v != 0) m_q.push_back(v);
                    if (m_lane == LANES - 1) m_wr_ack = 1;
                    else m_lane++;
                end
            end else if (!bus_if.VoiceControl_H) begin
                m_wr_active = 0;
            end
            if (set_err) m_terr = 1;
            else if (clr_err) m_terr = 0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("queue_level", 32'(queue_level), 32'(m_q.size()));
            checkOutput("phoneme_sel", 32'(phoneme_sel), 32'(m_sel));
            checkOutput("start", 32'(start_phoneme_output), 32'(m_phase == M_WAIT_BUSY));
            checkOutput("finish", 32'(phoneme_speech_finish), 32'(m_phase == M_FINISH));
            checkOutput("speech_idle", 32'(speech_idle), 32'(m_q.size() == 0 && m_phase == M_IDLE));
            checkOutput("timeout_err", 32'(timeout_err), 32'(m_terr));
            checkOutput("dtack_l", 32'(bus_if.VoiceDtack_L),
                        32'(!(m_wr_active && m_wr_ack && bus_if.VoiceControl_H)));
        end
    end

    // Monitor: phoneme codes at each start, start run length, finish pulse count.
    logic [7:0] started_q[$];
    int  finish_cnt = 0;
    int  start_run  = 0;
    int  last_run   = 0;
    bit  prev_start = 0;
    always @(negedge clk) begin
        if (!rst_L) begin
            prev_start = 0; start_run = 0;
        end else begin
            if (start_phoneme_output && !prev_start) started_q.push_back(phoneme_sel);
            if (start_phoneme_output) start_run++;
            else if (prev_start) begin last_run = start_run; start_run = 0; end
            if (phoneme_speech_finish) finish_cnt++;
            prev_start = start_phoneme_output;
        end
    end

    // Engine: mode 0 answers starts after random delay and busy length; 1 holds busy; 2 is dead.
    int engine_mode = 0;
    int eng_state   = 0;
    int eng_cnt     = 0;
    initial begin
        busy = 1'b0;
        forever begin
            @(posedge clk); #3;
            case (engine_mode)
                1: begin busy = 1'b1; eng_state = 0; end
                2: begin busy = 1'b0; eng_state = 0; end
                default: begin
                    if (eng_state == 0) begin
                        busy = 1'b0;
                        if (start_phoneme_output) begin
                            eng_cnt = $urandom_range(0, 2); eng_state = 1;
                        end
                    end else if (eng_state == 1) begin
                        if (eng_cnt == 0) begin
                            busy = 1'b1; eng_cnt = $urandom_range(0, 4); eng_state = 2;
                        end else eng_cnt--;
                    end else begin
                        if (eng_cnt == 0) begin busy = 1'b0; eng_state = 0; end
                        else eng_cnt--;
                    end
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic busStart(input logic [15:0] word);
        tick();
        bus_if.data = word;
        bus_if.VoiceControl_H = 1'b1;
    endtask

    task automatic busWaitAck(input int bound, output int cycles);
        cycles = 0;
        while (bus_if.VoiceDtack_L !== 1'b0 && cycles < bound) begin
            tick();
            cycles++;
        end
        checkOutput("ack_seen", 32'(bus_if.VoiceDtack_L), 32'h0);
    endtask

    task automatic busRelease();
        tick();
        bus_if.VoiceControl_H = 1'b0;
        tick();
    endtask

    task automatic applyStimulus(input logic [15:0] word, output int latency);
        busStart(word);
        busWaitAck(3000, latency);
        busRelease();
    endtask

    task automatic waitIdle(input int bound);
        int n = 0;
        while (!(speech_idle === 1'b1 && eng_state == 0 && busy == 1'b0) && n < bound) begin
            tick();
            n++;
        end
        checkOutput("drain_idle", 32'(speech_idle), 32'h1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        int lat, s0, f0;
        logic [15:0] w;
        rst_L = 1'b0;
        bus_if.VoiceControl_H = 1'b0;
        bus_if.data = '0;
        repeat (3) tick();
        check_en = 1;
        checkOutput("reset_level", 32'(queue_level), 32'h0);
        checkOutput("reset_dtack", 32'(bus_if.VoiceDtack_L), 32'h1);
        checkOutput("reset_idle", 32'(speech_idle), 32'h1);
        checkOutput("reset_sel", 32'(phoneme_sel), 32'h0);
        rst_L = 1'b1;
        tick();

        $display("[TB] single phoneme write 2A00");
        s0 = started_q.size(); f0 = finish_cnt;
        applyStimulus(16'h2A00, lat);
        checkOutput("ack_latency", 32'(lat), 32'd3);
        waitIdle(500);
        checkOutput("t1_starts", 32'(started_q.size()), 32'(s0 + 1));
        if (started_q.size() > s0) checkOutput("t1_code", 32'(started_q[s0]), 32'h2A);
        checkOutput("t1_finish", 32'(finish_cnt), 32'(f0 + 1));

        $display("[TB] two phoneme write 1B2C");
        s0 = started_q.size(); f0 = finish_cnt;
        applyStimulus(16'h1B2C, lat);
        waitIdle(500);
        checkOutput("t2_starts", 32'(started_q.size()), 32'(s0 + 2));
        if (started_q.size() > s0 + 1) begin
            checkOutput("t2_first", 32'(started_q[s0]), 32'h2C);
            checkOutput("t2_second", 32'(started_q[s0+1]), 32'h1B);
        end
        checkOutput("t2_finish", 32'(finish_cnt), 32'(f0 + 2));

        $display("[TB] full queue stall");
        engine_mode = 1;
        repeat (2) tick();
        applyStimulus(16'h0001, lat);
        repeat (4) tick();
        for (int i = 0; i < DEPTH; i++) applyStimulus(16'h0002, lat);
        checkOutput("t3_full_level", 32'(queue_level), 32'd16);
        busStart(16'h0003);
        repeat (40) tick();
        checkOutput("t3_no_ack", 32'(bus_if.VoiceDtack_L), 32'h1);
        checkOutput("t3_still_full", 32'(queue_level), 32'd16);
        engine_mode = 0;
        busWaitAck(3000, lat);
        busRelease();
        waitIdle(3000);

        $display("[TB] start timeout");
        engine_mode = 2;
        f0 = finish_cnt;
        applyStimulus(16'h0005, lat);
        lat = 0;
        while (finish_cnt == f0 && lat < 1500) begin tick(); lat++; end
        checkOutput("t4_finish", 32'(finish_cnt), 32'(f0 + 1));
        checkOutput("t4_start_cycles", 32'(last_run), 32'd1024);
        checkOutput("t4_err_set", 32'(timeout_err), 32'h1);
        engine_mode = 0;
        repeat (2) tick();
        applyStimulus(16'h0007, lat);
        checkOutput("t4_err_cleared", 32'(timeout_err), 32'h0);
        waitIdle(500);

        $display("[TB] reset during playback");
        engine_mode = 1;
        repeat (2) tick();
        applyStimulus(16'h0001, lat);
        repeat (5) tick();
        applyStimulus(16'h0101, lat);
        applyStimulus(16'h0101, lat);
        applyStimulus(16'h0001, lat);
        checkOutput("t5_level", 32'(queue_level), 32'd5);
        rst_L = 1'b0;
        #1;
        checkOutput("t5_rst_level", 32'(queue_level), 32'h0);
        checkOutput("t5_rst_start", 32'(start_phoneme_output), 32'h0);
        checkOutput("t5_rst_finish", 32'(phoneme_speech_finish), 32'h0);
        checkOutput("t5_rst_sel", 32'(phoneme_sel), 32'h0);
        checkOutput("t5_rst_idle", 32'(speech_idle), 32'h1);
        f0 = finish_cnt;
        engine_mode = 0;
        repeat (3) tick();
        rst_L = 1'b1;
        repeat (20) tick();
        checkOutput("t5_no_finish", 32'(finish_cnt), 32'(f0));

        $display("[TB] all-ones word is plain data");
        s0 = started_q.size();
        applyStimulus(16'hFFFF, lat);
        waitIdle(500);
        checkOutput("ff_starts", 32'(started_q.size()), 32'(s0 + 2));
        if (started_q.size() > s0 + 1) begin
            checkOutput("ff_first", 32'(started_q[s0]), 32'hFF);
            checkOutput("ff_second", 32'(started_q[s0+1]), 32'hFF);
        end

        $display("[TB] random writes");
        for (int i = 0; i < 60; i++) begin
            for (int l = 0; l < LANES; l++)
                w[l*8 +: 8] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            applyStimulus(w, lat);
            repeat ($urandom_range(0, 5)) tick();
        end
        waitIdle(3000);

        check_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
